// File: rtl/sar_ctrl_pkg.sv
// Shared types and constants for the SAR conversion sequencer.
package sar_ctrl_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    IDLE,
    SMP,
    CONV,
    CRST,
    FIN
  } sar_state_e;

  // Default build-time configuration
  localparam int DEF_NBITS         = 8;
  localparam int DEF_SAMPLE_CYCLES = 2;
  localparam int DEF_TMO           = 15;

  // Ceiling log2 for sizing counters at elaboration time
  function automatic int clog2(input int value);
    int bits;
    int rem;
    bits = 0;
    rem  = value - 1;
    for (int i = 0; i < 32; i++) begin
      if (rem > 0) begin
        bits = bits + 1;
        rem  = rem >> 1;
      end
    end
    return bits;
  endfunction

  // Counter width that is never narrower than one bit
  function automatic int width_min1(input int value);
    int w;
    w = clog2(value);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sar_cmp_timer.sv
// Comparator-decision timeout counter: counts cycles while enabled, saturates
// at TMO and flags the cycle in which the count reaches TMO.
module sar_cmp_timer
  import sar_ctrl_pkg::*;
#(
  parameter int TMO = DEF_TMO
) (
  input  logic CK,
  input  logic R,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int TW = width_min1(TMO + 1);
  localparam logic [TW-1:0] TMO_V  = TW'(TMO);
  localparam logic [TW-1:0] TMO_M1 = TW'(TMO - 1);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  // Next count: clear has priority, otherwise count up and hold at TMO
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != TMO_V)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register
  always_ff @(posedge CK) begin
    if (R) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The enabled cycle that carries the count up to TMO is the expiring one,
  // so the strobe stays high for at most TMO cycles.
  assign expired = (cnt_q == TMO_V) || (enable && !clear && (cnt_q == TMO_M1));

endmodule

// File: rtl/sar_ctrl.sv
// SAR ADC sequencer: samples, then resolves NBITS MSB-first through the
// comparator strobe / done handshake and publishes the result with DONE.
module sar_ctrl
  import sar_ctrl_pkg::*;
#(
  parameter int NBITS         = DEF_NBITS,
  parameter int SAMPLE_CYCLES = DEF_SAMPLE_CYCLES,
  parameter int TMO           = DEF_TMO
) (
  input  logic             CK,
  input  logic             R,
  input  logic             START,
  input  logic             CMP_DONE,
  input  logic             CMP_OUT,
  output logic             SAMPLE,
  output logic             CMP_CLK,
  output logic [NBITS-1:0] DAC_P,
  output logic [NBITS-1:0] DATA,
  output logic             DONE,
  output logic             BUSY,
  output logic             ERR
);

  localparam int KW = width_min1(NBITS);
  localparam int SW = width_min1(SAMPLE_CYCLES + 1);
  localparam logic [KW-1:0] K_MSB    = KW'(NBITS - 1);
  localparam logic [SW-1:0] SMP_LAST = SW'(SAMPLE_CYCLES);

  sar_state_e       state_q;
  logic [KW-1:0]    k_q;
  logic [SW-1:0]    smp_cnt_q;
  logic [NBITS-1:0] result_q;
  logic             sample_q;
  logic             cmp_clk_q;
  logic [NBITS-1:0] dac_q;
  logic [NBITS-1:0] data_q;
  logic             done_q;
  logic             busy_q;
  logic             err_q;

  logic             in_conv;
  logic             tmo_expired;
  logic             bit_d;
  logic [NBITS-1:0] result_d;
  logic [NBITS-1:0] trial_first_d;
  logic [NBITS-1:0] trial_next_d;

  assign in_conv = (state_q == CONV);

  sar_cmp_timer #(
    .TMO(TMO)
  ) u_cmp_timer (
    .CK     (CK),
    .R      (R),
    .clear  (!in_conv),
    .enable (in_conv),
    .expired(tmo_expired)
  );

  // Bit decision (forced to 0 on timeout) and the trial words for upcoming bits
  always_comb begin
    bit_d         = CMP_DONE ? CMP_OUT : 1'b0;
    result_d      = result_q | (NBITS'(bit_d) << k_q);
    trial_first_d = NBITS'(1) << K_MSB;
    trial_next_d  = result_q | (NBITS'(1) << (k_q - 1'b1));
  end

  // Sequencer with registered outputs; each transition loads the outputs of
  // the state being entered so nothing combinational reaches the pins.
  always_ff @(posedge CK) begin
    if (R) begin
      state_q   <= IDLE;
      k_q       <= '0;
      smp_cnt_q <= '0;
      result_q  <= '0;
      sample_q  <= 1'b0;
      cmp_clk_q <= 1'b0;
      dac_q     <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (START) begin
            state_q   <= SMP;
            err_q     <= 1'b0;
            result_q  <= '0;
            k_q       <= K_MSB;
            smp_cnt_q <= SW'(1);
            sample_q  <= 1'b1;
            busy_q    <= 1'b1;
            dac_q     <= '0;
          end
        end

        SMP: begin
          if (smp_cnt_q == SMP_LAST) begin
            state_q   <= CONV;
            sample_q  <= 1'b0;
            cmp_clk_q <= 1'b1;
            dac_q     <= trial_first_d;
          end else begin
            smp_cnt_q <= smp_cnt_q + 1'b1;
          end
        end

        CONV: begin
          // A real decision beats a timeout landing in the same cycle
          if (CMP_DONE || tmo_expired) begin
            state_q   <= CRST;
            result_q  <= result_d;
            dac_q     <= result_d;
            cmp_clk_q <= 1'b0;
            if (!CMP_DONE) begin
              err_q <= 1'b1;
            end
          end
        end

        CRST: begin
          if (k_q == '0) begin
            state_q <= FIN;
            data_q  <= result_q;
            done_q  <= 1'b1;
            dac_q   <= '0;
          end else begin
            state_q   <= CONV;
            k_q       <= k_q - 1'b1;
            cmp_clk_q <= 1'b1;
            dac_q     <= trial_next_d;
          end
        end

        FIN: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign SAMPLE  = sample_q;
  assign CMP_CLK = cmp_clk_q;
  assign DAC_P   = dac_q;
  assign DATA    = data_q;
  assign DONE    = done_q;
  assign BUSY    = busy_q;
  assign ERR     = err_q;

endmodule

// File: tb/tb_sar_ctrl.sv
// Directed bench for the SAR sequencer with an ideal comparator model.
module tb_sar_ctrl;

  localparam int NB = 8;

  logic          CK = 1'b0;
  logic          R = 1'b1;
  logic          START = 1'b0;
  logic          CMP_DONE = 1'b0;
  logic          CMP_OUT;
  logic          SAMPLE;
  logic          CMP_CLK;
  logic [NB-1:0] DAC_P;
  logic [NB-1:0] DATA;
  logic          DONE;
  logic          BUSY;
  logic          ERR;
  logic [NB-1:0] code = '0;

  int n_checks = 0;
  int n_fail = 0;

  // Ideal comparator: input code at or above the DAC level reads as 1
  assign CMP_OUT = (code >= DAC_P);

  sar_ctrl #(
    .NBITS(8),
    .SAMPLE_CYCLES(2),
    .TMO(15)
  ) dut (
    .CK(CK),
    .R(R),
    .START(START),
    .CMP_DONE(CMP_DONE),
    .CMP_OUT(CMP_OUT),
    .SAMPLE(SAMPLE),
    .CMP_CLK(CMP_CLK),
    .DAC_P(DAC_P),
    .DATA(DATA),
    .DONE(DONE),
    .BUSY(BUSY),
    .ERR(ERR)
  );

  always #5 CK = ~CK;

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic test_reset();
    R = 1'b1;
    START = 1'b1;
    CMP_DONE = 1'b1;
    tick();
    tick();
    n_checks++; if (SAMPLE !== 1'b0) begin n_fail++; $display("FAIL reset_sample: got %b want 0", SAMPLE); end
    n_checks++; if (CMP_CLK !== 1'b0) begin n_fail++; $display("FAIL reset_cmp_clk: got %b want 0", CMP_CLK); end
    n_checks++; if (DAC_P !== 8'h00) begin n_fail++; $display("FAIL reset_dac: got %h want 00", DAC_P); end
    n_checks++; if (DATA !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", DATA); end
    n_checks++; if (DONE !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", DONE); end
    n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", BUSY); end
    n_checks++; if (ERR !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", ERR); end
    R = 1'b0;
    START = 1'b0;
    tick();
    n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_release_idle: busy got %b want 0", BUSY); end
  endtask

  task automatic test_nominal();
    logic [NB-1:0] exp_trial [8];
    int ntr, ndone, done_cyc;
    logic prev_clk;
    exp_trial = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
    ntr = 0; ndone = 0; done_cyc = -1; prev_clk = 1'b0;
    code = 8'hA5;
    CMP_DONE = 1'b1;
    START = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      tick();
      if (c == 1) START = 1'b0;
      n_checks++; if (SAMPLE !== (c <= 2)) begin n_fail++; $display("FAIL nominal_sample c%0d: got %b want %b", c, SAMPLE, (c <= 2)); end
      n_checks++; if (BUSY !== (c <= 19)) begin n_fail++; $display("FAIL nominal_busy c%0d: got %b want %b", c, BUSY, (c <= 19)); end
      if (c <= 2 || c == 19) begin
        n_checks++; if (DAC_P !== 8'h00) begin n_fail++; $display("FAIL nominal_dac_zero c%0d: got %h want 00", c, DAC_P); end
      end
      if (CMP_CLK && !prev_clk) begin
        if (ntr < 8) begin
          n_checks++; if (DAC_P !== exp_trial[ntr]) begin n_fail++; $display("FAIL nominal_trial%0d: got %h want %h", ntr, DAC_P, exp_trial[ntr]); end
        end
        ntr++;
      end
      prev_clk = CMP_CLK;
      if (DONE) begin ndone++; done_cyc = c; end
    end
    n_checks++; if (ntr !== 8) begin n_fail++; $display("FAIL nominal_trial_count: got %0d want 8", ntr); end
    n_checks++; if (ndone !== 1) begin n_fail++; $display("FAIL nominal_done_count: got %0d want 1", ndone); end
    n_checks++; if (done_cyc !== 19) begin n_fail++; $display("FAIL nominal_done_cycle: got %0d want 19", done_cyc); end
    n_checks++; if (DATA !== 8'hA5) begin n_fail++; $display("FAIL nominal_data: got %h want a5", DATA); end
    n_checks++; if (ERR !== 1'b0) begin n_fail++; $display("FAIL nominal_err: got %b want 0", ERR); end
  endtask

  task automatic test_codes();
    logic [NB-1:0] codes [2];
    logic [NB-1:0] hold_exp [2];
    codes = '{8'hFF, 8'h00};
    hold_exp = '{8'hA5, 8'hFF};
    CMP_DONE = 1'b1;
    for (int i = 0; i < 2; i++) begin
      int ndone;
      int done_cyc;
      ndone = 0; done_cyc = -1;
      code = codes[i];
      START = 1'b1;
      for (int c = 1; c <= 22; c++) begin
        tick();
        if (c == 1) START = 1'b0;
        if (c == 18) begin
          n_checks++; if (DATA !== hold_exp[i]) begin n_fail++; $display("FAIL codes_hold%0d: got %h want %h", i, DATA, hold_exp[i]); end
        end
        if (DONE) begin
          ndone++; done_cyc = c;
          n_checks++; if (DATA !== codes[i]) begin n_fail++; $display("FAIL codes_data%0d: got %h want %h", i, DATA, codes[i]); end
        end
      end
      n_checks++; if (ndone !== 1) begin n_fail++; $display("FAIL codes_done_count%0d: got %0d want 1", i, ndone); end
      n_checks++; if (done_cyc !== 19) begin n_fail++; $display("FAIL codes_done_cycle%0d: got %0d want 19", i, done_cyc); end
    end
  endtask

  task automatic test_slow_cmp();
    int hi, lo, nrise, ndone, done_cyc;
    logic prev;
    hi = 0; lo = 0; nrise = 0; ndone = 0; done_cyc = -1; prev = 1'b0;
    code = 8'h5A;
    CMP_DONE = 1'b0;
    START = 1'b1;
    for (int c = 1; c <= 50; c++) begin
      tick();
      if (c == 1) START = 1'b0;
      if (CMP_CLK) begin
        if (!prev) begin
          if (nrise > 0) begin
            n_checks++; if (lo !== 1) begin n_fail++; $display("FAIL slow_low_time bit%0d: got %0d want 1", nrise, lo); end
          end
          nrise++;
          hi = 0;
        end
        hi++;
      end else begin
        if (prev) begin
          n_checks++; if (hi !== 4) begin n_fail++; $display("FAIL slow_high_time bit%0d: got %0d want 4", nrise, hi); end
          lo = 0;
        end
        lo++;
      end
      prev = CMP_CLK;
      CMP_DONE = CMP_CLK && (hi == 4);
      if (DONE) begin ndone++; done_cyc = c; end
    end
    CMP_DONE = 1'b0;
    n_checks++; if (nrise !== 8) begin n_fail++; $display("FAIL slow_bit_count: got %0d want 8", nrise); end
    n_checks++; if (ndone !== 1) begin n_fail++; $display("FAIL slow_done_count: got %0d want 1", ndone); end
    n_checks++; if (done_cyc !== 43) begin n_fail++; $display("FAIL slow_done_cycle: got %0d want 43", done_cyc); end
    n_checks++; if (DATA !== 8'h5A) begin n_fail++; $display("FAIL slow_data: got %h want 5a", DATA); end
    n_checks++; if (ERR !== 1'b0) begin n_fail++; $display("FAIL slow_err: got %b want 0", ERR); end
  endtask

  task automatic test_timeout();
    int hi, nrise, ndone, done_cyc;
    logic prev;
    hi = 0; nrise = 0; ndone = 0; done_cyc = -1; prev = 1'b0;
    code = 8'hFF;
    CMP_DONE = 1'b0;
    START = 1'b1;
    for (int c = 1; c <= 140; c++) begin
      tick();
      if (c == 1) START = 1'b0;
      if (c == 17) begin
        n_checks++; if (ERR !== 1'b0) begin n_fail++; $display("FAIL timeout_err_before: got %b want 0", ERR); end
      end
      if (c == 18) begin
        n_checks++; if (ERR !== 1'b1) begin n_fail++; $display("FAIL timeout_err_first: got %b want 1", ERR); end
      end
      if (CMP_CLK) begin
        if (!prev) begin nrise++; hi = 0; end
        hi++;
      end else if (prev) begin
        n_checks++; if (hi !== 15) begin n_fail++; $display("FAIL timeout_high_time bit%0d: got %0d want 15", nrise, hi); end
      end
      prev = CMP_CLK;
      if (DONE) begin
        ndone++; done_cyc = c;
        n_checks++; if (DATA !== 8'h00) begin n_fail++; $display("FAIL timeout_data: got %h want 00", DATA); end
      end
    end
    n_checks++; if (ndone !== 1) begin n_fail++; $display("FAIL timeout_done_count: got %0d want 1", ndone); end
    n_checks++; if (done_cyc !== 131) begin n_fail++; $display("FAIL timeout_done_cycle: got %0d want 131", done_cyc); end
    n_checks++; if (ERR !== 1'b1) begin n_fail++; $display("FAIL timeout_err_sticky: got %b want 1", ERR); end
    // A new accepted START clears the flag
    CMP_DONE = 1'b1;
    START = 1'b1;
    ndone = 0;
    tick();
    START = 1'b0;
    n_checks++; if (ERR !== 1'b0) begin n_fail++; $display("FAIL timeout_err_clear: got %b want 0", ERR); end
    for (int c = 2; c <= 22; c++) begin
      tick();
      if (DONE) begin
        ndone++;
        n_checks++; if (DATA !== 8'hFF) begin n_fail++; $display("FAIL timeout_recover_data: got %h want ff", DATA); end
      end
    end
    n_checks++; if (ndone !== 1) begin n_fail++; $display("FAIL timeout_recover_done: got %0d want 1", ndone); end
  endtask

  task automatic test_back_to_back();
    int ndone, d0, d1;
    ndone = 0; d0 = -1; d1 = -1;
    code = 8'h3C;
    CMP_DONE = 1'b1;
    START = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (DONE) begin
        if (ndone == 0) d0 = c; else d1 = c;
        ndone++;
        n_checks++; if (DATA !== 8'h3C) begin n_fail++; $display("FAIL b2b_data: got %h want 3c", DATA); end
      end
      if (c == 20) begin
        n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_gap: busy got %b want 0", BUSY); end
      end
      if (c == 21) begin
        n_checks++; if (SAMPLE !== 1'b1) begin n_fail++; $display("FAIL b2b_resample: got %b want 1", SAMPLE); end
      end
      if (c == 40) START = 1'b0;
    end
    tick();
    n_checks++; if (ndone !== 2) begin n_fail++; $display("FAIL b2b_done_count: got %0d want 2", ndone); end
    n_checks++; if (d0 !== 19) begin n_fail++; $display("FAIL b2b_first_done: got %0d want 19", d0); end
    n_checks++; if (d1 !== 39) begin n_fail++; $display("FAIL b2b_second_done: got %0d want 39", d1); end
    n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL b2b_stop: busy got %b want 0", BUSY); end
  endtask

  task automatic test_ignore_start();
    int ndone, done_cyc, nsmp;
    ndone = 0; done_cyc = -1; nsmp = 0;
    code = 8'hC3;
    CMP_DONE = 1'b1;
    START = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (SAMPLE) nsmp++;
      if (DONE) begin ndone++; done_cyc = c; end
      if (c == 25) begin
        n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL ignore_no_restart: busy got %b want 0", BUSY); end
      end
      START = (c == 1) || (c == 3) || (c == 4) || (c == 19);
    end
    START = 1'b0;
    n_checks++; if (ndone !== 1) begin n_fail++; $display("FAIL ignore_done_count: got %0d want 1", ndone); end
    n_checks++; if (done_cyc !== 19) begin n_fail++; $display("FAIL ignore_done_cycle: got %0d want 19", done_cyc); end
    n_checks++; if (nsmp !== 2) begin n_fail++; $display("FAIL ignore_sample_cycles: got %0d want 2", nsmp); end
    n_checks++; if (DATA !== 8'hC3) begin n_fail++; $display("FAIL ignore_data: got %h want c3", DATA); end
  endtask

  task automatic test_reset_abort();
    int ndone, done_cyc;
    ndone = 0; done_cyc = -1;
    code = 8'hA5;
    CMP_DONE = 1'b1;
    START = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (c == 1) START = 1'b0;
      if (DONE) ndone++;
    end
    n_checks++; if (DAC_P !== 8'hB0) begin n_fail++; $display("FAIL abort_bit4_trial: got %h want b0", DAC_P); end
    R = 1'b1;
    tick();
    R = 1'b0;
    n_checks++; if (SAMPLE !== 1'b0) begin n_fail++; $display("FAIL abort_sample: got %b want 0", SAMPLE); end
    n_checks++; if (CMP_CLK !== 1'b0) begin n_fail++; $display("FAIL abort_cmp_clk: got %b want 0", CMP_CLK); end
    n_checks++; if (DAC_P !== 8'h00) begin n_fail++; $display("FAIL abort_dac: got %h want 00", DAC_P); end
    n_checks++; if (DATA !== 8'h00) begin n_fail++; $display("FAIL abort_data: got %h want 00", DATA); end
    n_checks++; if (DONE !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %b want 0", DONE); end
    n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", BUSY); end
    n_checks++; if (ERR !== 1'b0) begin n_fail++; $display("FAIL abort_err: got %b want 0", ERR); end
    for (int c = 0; c < 12; c++) begin
      tick();
      if (DONE) ndone++;
    end
    n_checks++; if (ndone !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d want 0", ndone); end
    n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL abort_stays_idle: busy got %b want 0", BUSY); end
    code = 8'h69;
    START = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      tick();
      if (c == 1) START = 1'b0;
      if (DONE) begin ndone++; done_cyc = c; end
    end
    n_checks++; if (ndone !== 1) begin n_fail++; $display("FAIL abort_restart_done_count: got %0d want 1", ndone); end
    n_checks++; if (done_cyc !== 19) begin n_fail++; $display("FAIL abort_restart_done_cycle: got %0d want 19", done_cyc); end
    n_checks++; if (DATA !== 8'h69) begin n_fail++; $display("FAIL abort_restart_data: got %h want 69", DATA); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_codes();
    test_slow_cmp();
    test_timeout();
    test_back_to_back();
    test_ignore_start();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation still running at %0t, limit 200000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
